// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter
// Merges the B32P fetch and data ports onto one memory bus: round-robin with
// data-first tie-break, registered bus outputs, watchdog for hung accesses.
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  // instruction fetch port
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_q,
  output logic                  i_done,
  // data port
  input  logic                  d_start,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_data,
  input  logic                  d_we,
  output logic [DATA_WIDTH-1:0] d_q,
  output logic                  d_done,
  // memory bus
  output logic                  bus_start,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_we,
  input  logic [DATA_WIDTH-1:0] bus_q,
  input  logic                  bus_done,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_I = 3'd1,
    S_BUSY_D = 3'd2,
    S_RESP_I = 3'd3,
    S_RESP_D = 3'd4
  } state_t;

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              WDOG_EN  = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    bus_start_q, bus_start_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0]   bus_data_q, bus_data_d;
  logic                    bus_we_q, bus_we_d;
  logic [DATA_WIDTH-1:0]   i_q_q, i_q_d;
  logic [DATA_WIDTH-1:0]   d_q_q, d_q_d;
  logic                    i_done_q, i_done_d;
  logic                    d_done_q, d_done_d;
  logic                    timeout_err_q, timeout_err_d;

  logic                    grant_d_port;
  logic                    grant_i_port;
  logic                    busy_expired;

  // On a tie, the port that did not win last time gets the bus.
  assign grant_d_port = d_start && (!i_start || (last_grant_q == GRANT_I));
  assign grant_i_port = i_start && !grant_d_port;
  assign busy_expired = WDOG_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    bus_start_d   = bus_start_q;
    bus_addr_d    = bus_addr_q;
    bus_data_d    = bus_data_q;
    bus_we_d      = bus_we_q;
    i_q_d         = i_q_q;
    d_q_d         = d_q_q;
    i_done_d      = 1'b0;
    d_done_d      = 1'b0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (grant_d_port) begin
          bus_addr_d   = d_addr;
          bus_data_d   = d_data;
          bus_we_d     = d_we;
          bus_start_d  = 1'b1;
          cnt_d        = '0;
          last_grant_d = GRANT_D;
          state_d      = S_BUSY_D;
        end else if (grant_i_port) begin
          bus_addr_d   = i_addr;
          bus_data_d   = '0;
          bus_we_d     = 1'b0;
          bus_start_d  = 1'b1;
          cnt_d        = '0;
          last_grant_d = GRANT_I;
          state_d      = S_BUSY_I;
        end
      end

      S_BUSY_I: begin
        // A completion arriving on the expiry cycle still counts as success.
        if (bus_done) begin
          bus_start_d = 1'b0;
          i_q_d       = bus_q;
          i_done_d    = 1'b1;
          state_d     = S_RESP_I;
        end else if (busy_expired) begin
          bus_start_d   = 1'b0;
          i_q_d         = '0;
          i_done_d      = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_RESP_I;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_BUSY_D: begin
        if (bus_done) begin
          bus_start_d = 1'b0;
          d_q_d       = bus_q;
          d_done_d    = 1'b1;
          state_d     = S_RESP_D;
        end else if (busy_expired) begin
          bus_start_d   = 1'b0;
          d_q_d         = '0;
          d_done_d      = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_RESP_D;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP_I, S_RESP_D: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        bus_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= GRANT_I;
      cnt_q         <= '0;
      bus_start_q   <= 1'b0;
      bus_addr_q    <= '0;
      bus_data_q    <= '0;
      bus_we_q      <= 1'b0;
      i_q_q         <= '0;
      d_q_q         <= '0;
      i_done_q      <= 1'b0;
      d_done_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      bus_start_q   <= bus_start_d;
      bus_addr_q    <= bus_addr_d;
      bus_data_q    <= bus_data_d;
      bus_we_q      <= bus_we_d;
      i_q_q         <= i_q_d;
      d_q_q         <= d_q_d;
      i_done_q      <= i_done_d;
      d_done_q      <= d_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus_start   = bus_start_q;
  assign bus_addr    = bus_addr_q;
  assign bus_data    = bus_data_q;
  assign bus_we      = bus_we_q;
  assign i_q         = i_q_q;
  assign d_q         = d_q_q;
  assign i_done      = i_done_q;
  assign d_done      = d_done_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter
// Directed self-checking bench for mem_bus_arbiter (watchdog TIMEOUT = 8).
// Revision: 1.0
// ============================================================================
module tb_mem_bus_arbiter;

  localparam int AW = 27;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          i_start;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_q;
  logic          i_done;
  logic          d_start;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_data;
  logic          d_we;
  logic [DW-1:0] d_q;
  logic          d_done;
  logic          bus_start;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data;
  logic          bus_we;
  logic [DW-1:0] bus_q;
  logic          bus_done;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_addr     (i_addr),
    .i_q        (i_q),
    .i_done     (i_done),
    .d_start    (d_start),
    .d_addr     (d_addr),
    .d_data     (d_data),
    .d_we       (d_we),
    .d_q        (d_q),
    .d_done     (d_done),
    .bus_start  (bus_start),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .bus_we     (bus_we),
    .bus_q      (bus_q),
    .bus_done   (bus_done),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_start  = 1'b0;
    i_addr   = '0;
    d_start  = 1'b0;
    d_addr   = '0;
    d_data   = '0;
    d_we     = 1'b0;
    bus_q    = '0;
    bus_done = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus_start !== 1'b0) begin errors++; $display("FAIL rst_bus_start: got %h exp 0", bus_start); end
    checks++; if (bus_addr !== '0) begin errors++; $display("FAIL rst_bus_addr: got %h exp 0", bus_addr); end
    checks++; if ({bus_we, bus_data} !== '0) begin errors++; $display("FAIL rst_bus_we_data: got %h exp 0", {bus_we, bus_data}); end
    checks++; if ({i_done, d_done, timeout_err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b exp 000", {i_done, d_done, timeout_err}); end
    checks++; if ({i_q, d_q} !== '0) begin errors++; $display("FAIL rst_q: got %h exp 0", {i_q, d_q}); end
  endtask

  task automatic test_single_fetch();
    i_start = 1'b1;
    i_addr  = 27'h000100;
    step();  // cycle 1
    checks++; if (bus_start !== 1'b1) begin errors++; $display("FAIL fetch_start: got %h exp 1", bus_start); end
    checks++; if (bus_addr !== 27'h100) begin errors++; $display("FAIL fetch_addr: got %h exp 100", bus_addr); end
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL fetch_we: got %h exp 0", bus_we); end
    checks++; if ({i_done, d_done} !== 2'b00) begin errors++; $display("FAIL fetch_early_done: got %b exp 00", {i_done, d_done}); end
    bus_done = 1'b1;
    bus_q    = 32'hDEADBEEF;
    step();  // cycle 2
    bus_done = 1'b0;
    i_start  = 1'b0;
    checks++; if (i_done !== 1'b1) begin errors++; $display("FAIL fetch_done: got %h exp 1", i_done); end
    checks++; if (i_q !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_q: got %h exp deadbeef", i_q); end
    checks++; if ({bus_start, d_done} !== 2'b00) begin errors++; $display("FAIL fetch_release: got %b exp 00", {bus_start, d_done}); end
    step();  // cycle 3
    step();  // cycle 4
    checks++; if ({bus_start, i_done, d_done} !== 3'b000) begin errors++; $display("FAIL fetch_idle: got %b exp 000", {bus_start, i_done, d_done}); end
  endtask

  task automatic test_data_write();
    d_start = 1'b1;
    d_we    = 1'b1;
    d_addr  = 27'h7FFFFFF;
    d_data  = 32'h12345678;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if ({bus_start, bus_we} !== 2'b11) begin errors++; $display("FAIL wr_ctl_c%0d: got %b exp 11", k, {bus_start, bus_we}); end
      checks++; if (bus_addr !== 27'h7FFFFFF || bus_data !== 32'h12345678) begin errors++; $display("FAIL wr_bus_c%0d: got %h/%h exp 7ffffff/12345678", k, bus_addr, bus_data); end
      checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL wr_early_done_c%0d: got %h exp 0", k, d_done); end
      if (k == 3) begin
        bus_done = 1'b1;
        bus_q    = 32'hA5A50000;
      end
    end
    step();  // cycle 4
    bus_done = 1'b0;
    d_start  = 1'b0;
    d_we     = 1'b0;
    checks++; if ({d_done, i_done, bus_start} !== 3'b100) begin errors++; $display("FAIL wr_done: got %b exp 100", {d_done, i_done, bus_start}); end
    checks++; if (d_q !== 32'hA5A50000) begin errors++; $display("FAIL wr_dq: got %h exp a5a50000", d_q); end
    checks++; if (i_q !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_iq_hold: got %h exp deadbeef", i_q); end
    step();  // cycle 5
    checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse: got %h exp 0", d_done); end
  endtask

  task automatic test_done_at_expiry();
    d_start = 1'b1;
    d_we    = 1'b0;
    d_addr  = 27'h33;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (bus_start !== 1'b1) begin errors++; $display("FAIL exp_start_c%0d: got %h exp 1", k, bus_start); end
    end
    bus_done = 1'b1;
    bus_q    = 32'hCAFEF00D;
    step();  // cycle 9
    bus_done = 1'b0;
    d_start  = 1'b0;
    checks++; if ({d_done, bus_start, timeout_err} !== 3'b100) begin errors++; $display("FAIL exp_done: got %b exp 100", {d_done, bus_start, timeout_err}); end
    checks++; if (d_q !== 32'hCAFEF00D) begin errors++; $display("FAIL exp_dq: got %h exp cafef00d", d_q); end
    step();
  endtask

  task automatic test_watchdog();
    i_start = 1'b1;
    i_addr  = 27'h55;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if ({bus_start, timeout_err, i_done} !== 3'b100) begin errors++; $display("FAIL wd_busy_c%0d: got %b exp 100", k, {bus_start, timeout_err, i_done}); end
    end
    i_start = 1'b0;
    step();  // cycle 9
    checks++; if ({bus_start, i_done, d_done} !== 3'b010) begin errors++; $display("FAIL wd_abort: got %b exp 010", {bus_start, i_done, d_done}); end
    checks++; if (i_q !== '0) begin errors++; $display("FAIL wd_iq: got %h exp 0", i_q); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_err: got %h exp 1", timeout_err); end
    for (int k = 10; k <= 12; k++) begin
      step();
      checks++; if ({timeout_err, i_done, bus_start} !== 3'b100) begin errors++; $display("FAIL wd_sticky_c%0d: got %b exp 100", k, {timeout_err, i_done, bus_start}); end
    end
  endtask

  task automatic test_reset_mid();
    d_start = 1'b1;
    d_we    = 1'b1;
    d_addr  = 27'h44;
    d_data  = 32'h99;
    step();  // cycle 1
    checks++; if (bus_start !== 1'b1) begin errors++; $display("FAIL rmid_start: got %h exp 1", bus_start); end
    step();  // cycle 2
    reset = 1'b1;
    step();  // cycle 3
    reset    = 1'b0;
    d_start  = 1'b0;
    d_we     = 1'b0;
    bus_done = 1'b1;
    bus_q    = 32'h77777777;
    checks++; if ({bus_start, bus_we, bus_addr, bus_data} !== '0) begin errors++; $display("FAIL rmid_bus: got %h exp 0", {bus_start, bus_we, bus_addr, bus_data}); end
    checks++; if ({d_q, i_q, timeout_err, i_done, d_done} !== '0) begin errors++; $display("FAIL rmid_ports: got %h exp 0", {d_q, i_q, timeout_err, i_done, d_done}); end
    step();  // cycle 4
    bus_done = 1'b0;
    checks++; if ({d_done, i_done, bus_start} !== 3'b000) begin errors++; $display("FAIL rmid_stray: got %b exp 000", {d_done, i_done, bus_start}); end
    step();  // cycle 5
    checks++; if ({d_done, d_q} !== '0) begin errors++; $display("FAIL rmid_stray2: got %h exp 0", {d_done, d_q}); end
  endtask

  task automatic test_stray_done();
    bus_done = 1'b1;
    bus_q    = 32'h11111111;
    step();
    bus_done = 1'b0;
    checks++; if ({i_done, d_done, bus_start} !== 3'b000) begin errors++; $display("FAIL stray_done: got %b exp 000", {i_done, d_done, bus_start}); end
    step();
    checks++; if ({i_done, d_done} !== 2'b00 || {i_q, d_q} !== '0) begin errors++; $display("FAIL stray_q: got %b/%h exp 00/0", {i_done, d_done}, {i_q, d_q}); end
    // The arbiter must still be in IDLE: a fresh fetch is granted next cycle.
    i_start = 1'b1;
    i_addr  = 27'h2A;
    step();
    checks++; if (bus_start !== 1'b1 || bus_addr !== 27'h2A) begin errors++; $display("FAIL stray_idle: got %h/%h exp 1/2a", bus_start, bus_addr); end
    bus_done = 1'b1;
    bus_q    = 32'h0BADF00D;
    step();
    bus_done = 1'b0;
    i_start  = 1'b0;
    checks++; if (i_done !== 1'b1 || i_q !== 32'h0BADF00D) begin errors++; $display("FAIL stray_fetch: got %h/%h exp 1/0badf00d", i_done, i_q); end
    step();
  endtask

  task automatic test_back_to_back();
    logic is_d_grant [4];
    logic is_d_done  [4];
    int   gcyc       [4];
    int   ng;
    int   nd;
    ng = 0;
    nd = 0;
    do_reset();
    i_addr  = 27'h10;
    d_addr  = 27'h20;
    d_we    = 1'b0;
    i_start = 1'b1;
    d_start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (i_done || d_done) begin
        if (nd < 4) is_d_done[nd] = d_done;
        nd++;
      end
      if (bus_start) begin
        if (ng < 4) begin
          is_d_grant[ng] = (bus_addr == 27'h20);
          gcyc[ng]       = k;
        end
        ng++;
        bus_done = 1'b1;
        bus_q    = (bus_addr == 27'h20) ? 32'hD0000020 : 32'h10000010;
      end else begin
        bus_done = 1'b0;
      end
    end
    checks++; if (ng !== 4) begin errors++; $display("FAIL b2b_grants: got %0d exp 4", ng); end
    checks++; if (nd !== 4) begin errors++; $display("FAIL b2b_dones: got %0d exp 4", nd); end
    if (ng >= 4 && nd >= 4) begin
      for (int j = 0; j < 4; j++) begin
        checks++; if (is_d_grant[j] !== (j % 2 == 0)) begin errors++; $display("FAIL b2b_grant%0d: got d=%b exp d=%b", j, is_d_grant[j], (j % 2 == 0)); end
        checks++; if (is_d_done[j] !== (j % 2 == 0)) begin errors++; $display("FAIL b2b_done%0d: got d=%b exp d=%b", j, is_d_done[j], (j % 2 == 0)); end
        checks++; if (gcyc[j] !== 1 + 3 * j) begin errors++; $display("FAIL b2b_cycle%0d: got %0d exp %0d", j, gcyc[j], 1 + 3 * j); end
      end
    end
    checks++; if (i_q !== 32'h10000010 || d_q !== 32'hD0000020) begin errors++; $display("FAIL b2b_q: got %h/%h exp 10000010/d0000020", i_q, d_q); end
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_data_write();
    test_done_at_expiry();
    test_watchdog();
    test_reset_mid();
    test_stray_done();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test exp finish before 200000");
    $fatal(1, "time limit exceeded");
  end

endmodule
`default_nettype wire
